instr_encoder: RTL and testbench

Streaming MIPS instruction encoder: the inverse of the pipeline's instruction decoder. It accepts a mnemonic code plus operand fields over a valid/ready handshake and packs them into 32-bit instruction words. Words are buffered in a small FIFO and emitted with a running word address. It sits in front of the instruction-memory loader and the testbench program generator, producing the same 21-instruction subset the pipeline decodes.

---
 rtl/instr_encoder.sv | 119 +++++++++++
 tb/tb_instr_encoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder: packs mnemonic + operand descriptors into
// 32-bit words and queues them in a small FIFO, emitted with a running address.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_mnem,
  input  logic [4:0]                 in_rs,
  input  logic [4:0]                 in_rt,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_shamt,
  input  logic [25:0]                in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_addr,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       err
);

  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW:0]   L_FULL = (AW + 1)'(DEPTH);

  localparam logic [4:0] M_ADD  = 5'd0,  M_SUB  = 5'd1,  M_ORI    = 5'd2,  M_LUI  = 5'd3;
  localparam logic [4:0] M_LW   = 5'd4,  M_SW   = 5'd5,  M_BEQ    = 5'd6,  M_J    = 5'd7;
  localparam logic [4:0] M_JAL  = 5'd8,  M_JR   = 5'd9,  M_JALR   = 5'd10, M_LB   = 5'd11;
  localparam logic [4:0] M_SB   = 5'd12, M_LH   = 5'd13, M_SH     = 5'd14, M_LBU  = 5'd15;
  localparam logic [4:0] M_LHU  = 5'd16, M_SLT  = 5'd17, M_SLL    = 5'd18, M_SLLV = 5'd19;
  localparam logic [4:0] M_BLTZAL = 5'd20;

  logic [31:0]   w_word;
  logic          w_legal;
  logic          w_push;
  logic          w_pop;
  logic [15:0]   w_imm16;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [31:0]   r_addr;
  logic          r_err;

  assign w_imm16 = in_imm[15:0];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_word  = 32'h0;
    w_legal = 1'b1;
    case (in_mnem)
      M_ADD:    w_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100000};
      M_SUB:    w_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100010};
      M_SLT:    w_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b101010};
      M_SLLV:   w_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b000100};
      M_SLL:    w_word = {6'b000000, 5'd0, in_rt, in_rd, in_shamt, 6'b000000};
      M_JR:     w_word = {6'b000000, in_rs, 5'd0, 5'd0, 5'd0, 6'b001000};
      M_JALR:   w_word = {6'b000000, in_rs, 5'd0, in_rd, 5'd0, 6'b001001};
      M_ORI:    w_word = {6'b001101, in_rs, in_rt, w_imm16};
      M_LUI:    w_word = {6'b001111, 5'd0, in_rt, w_imm16};
      M_LW:     w_word = {6'b100011, in_rs, in_rt, w_imm16};
      M_SW:     w_word = {6'b101011, in_rs, in_rt, w_imm16};
      M_BEQ:    w_word = {6'b000100, in_rs, in_rt, w_imm16};
      M_LB:     w_word = {6'b100000, in_rs, in_rt, w_imm16};
      M_SB:     w_word = {6'b101000, in_rs, in_rt, w_imm16};
      M_LH:     w_word = {6'b100001, in_rs, in_rt, w_imm16};
      M_SH:     w_word = {6'b101001, in_rs, in_rt, w_imm16};
      M_LBU:    w_word = {6'b100100, in_rs, in_rt, w_imm16};
      M_LHU:    w_word = {6'b100101, in_rs, in_rt, w_imm16};
      M_BLTZAL: w_word = {6'b000001, in_rs, 5'b10000, w_imm16};
      M_J:      w_word = {6'b000010, in_imm};
      M_JAL:    w_word = {6'b000011, in_imm};
      default:  w_legal = 1'b0;
    endcase
  end

  // in_ready deliberately ignores a same-cycle pop to keep it off the out_ready path.
  assign in_ready  = (r_level != L_FULL);
  assign out_valid = (r_level != '0);
  assign w_push    = in_valid & in_ready & w_legal;
  assign w_pop     = out_valid & out_ready;

  // NOTE: the storage array has no reset; stale entries are never visible
  // because out_instr is masked by the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_addr   <= BASE_ADDR;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_addr   <= r_addr + 32'd4;
      end
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
      if (in_valid && in_ready && !w_legal) r_err <= 1'b1;
    end
  end

  assign out_instr = out_valid ? r_mem[r_rd_ptr] : 32'h0;
  assign out_addr  = r_addr;
  assign level     = r_level;
  assign err       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: per-mnemonic encoding table followed by
// hand-written streaming, full-FIFO, illegal-code and mid-stream reset sequences.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_mnem, in_rs, in_rt, in_rd, in_shamt;
  logic [25:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [2:0]  level;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_addr;

  typedef struct {
    string       name;
    logic [4:0]  mnem, rs, rt, rd, shamt;
    logic [25:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[21];

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_3000)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .level(level), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [4:0] m, rs, rt, rd, sh,
                              input logic [25:0] imm, input logic [31:0] exp);
    vec_t v;
    v.name = nm; v.mnem = m; v.rs = rs; v.rt = rt; v.rd = rd;
    v.shamt = sh; v.imm = imm; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input logic [4:0] m, rs, rt, rd, sh, input logic [25:0] imm);
    in_valid = 1'b1;
    in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
    exp_addr = 32'h3000;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0;

    vecs[0]  = mk("add",    5'd0,  5'd1,  5'd2,  5'd3,  5'd0, 26'h0,       32'h0022_1820);
    vecs[1]  = mk("sub",    5'd1,  5'd4,  5'd5,  5'd6,  5'd7, 26'h0,       32'h0085_3022);
    vecs[2]  = mk("slt",    5'd17, 5'd31, 5'd31, 5'd31, 5'd31, 26'h0,      32'h03FF_F82A);
    vecs[3]  = mk("sllv",   5'd19, 5'd2,  5'd3,  5'd4,  5'd5, 26'h0,       32'h0043_2004);
    vecs[4]  = mk("jr",     5'd9,  5'd31, 5'd1,  5'd2,  5'd3, 26'h0,       32'h03E0_0008);
    vecs[5]  = mk("jalr",   5'd10, 5'd5,  5'd6,  5'd31, 5'd1, 26'h0,       32'h00A0_F809);
    vecs[6]  = mk("sll",    5'd18, 5'd9,  5'd1,  5'd2,  5'd4, 26'h0,       32'h0001_1100);
    vecs[7]  = mk("ori",    5'd2,  5'd0,  5'd5,  5'd0,  5'd0, 26'h2AB1234, 32'h3405_1234);
    vecs[8]  = mk("lui",    5'd3,  5'd7,  5'd8,  5'd0,  5'd0, 26'h000ABCD, 32'h3C08_ABCD);
    vecs[9]  = mk("lw",     5'd4,  5'd29, 5'd8,  5'd0,  5'd0, 26'h000FFFC, 32'h8FA8_FFFC);
    vecs[10] = mk("sw",     5'd5,  5'd29, 5'd31, 5'd0,  5'd0, 26'h0000010, 32'hAFBF_0010);
    vecs[11] = mk("beq",    5'd6,  5'd1,  5'd2,  5'd0,  5'd0, 26'h0000003, 32'h1022_0003);
    vecs[12] = mk("lb",     5'd11, 5'd3,  5'd4,  5'd0,  5'd0, 26'h0000001, 32'h8064_0001);
    vecs[13] = mk("sb",     5'd12, 5'd3,  5'd4,  5'd0,  5'd0, 26'h0000002, 32'hA064_0002);
    vecs[14] = mk("lh",     5'd13, 5'd3,  5'd4,  5'd0,  5'd0, 26'h0000004, 32'h8464_0004);
    vecs[15] = mk("sh",     5'd14, 5'd3,  5'd4,  5'd0,  5'd0, 26'h0000006, 32'hA464_0006);
    vecs[16] = mk("lbu",    5'd15, 5'd3,  5'd4,  5'd0,  5'd0, 26'h0008000, 32'h9064_8000);
    vecs[17] = mk("lhu",    5'd16, 5'd3,  5'd4,  5'd0,  5'd0, 26'h000FFFE, 32'h9464_FFFE);
    vecs[18] = mk("bltzal", 5'd20, 5'd4,  5'd7,  5'd0,  5'd0, 26'h000FFFF, 32'h0490_FFFF);
    vecs[19] = mk("j",      5'd7,  5'd0,  5'd0,  5'd0,  5'd0, 26'h3FFFFFF, 32'h0BFF_FFFF);
    vecs[20] = mk("jal",    5'd8,  5'd0,  5'd0,  5'd0,  5'd0, 26'h0000C03, 32'h0C00_0C03);

    // Reset state
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level",     32'(level),     32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_err",       32'(err),       32'd0);
    check("rst_out_addr",  out_addr,       32'h3000);
    check("rst_out_instr", out_instr,      32'h0);

    // Table: push one descriptor, check head word next cycle, then pop it
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].mnem, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].shamt, vecs[i].imm);
      tick();
      in_valid = 1'b0;
      check({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
      check({vecs[i].name, "_instr"}, out_instr, vecs[i].exp);
      check({vecs[i].name, "_addr"},  out_addr,  exp_addr);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_addr += 32'd4;
      check({vecs[i].name, "_drained"}, 32'(level), 32'd0);
    end

    // Back-to-back stream with out_ready held high
    do_reset();
    out_ready = 1'b1;
    drive(5'd2, 5'd0, 5'd5, 5'd0, 5'd0, 26'h0001234);
    tick();
    check("s0_instr", out_instr, 32'h3405_1234);
    check("s0_addr",  out_addr,  32'h3000);
    drive(5'd18, 5'd9, 5'd1, 5'd2, 5'd4, 26'h0);
    tick();
    check("s1_instr", out_instr, 32'h0001_1100);
    check("s1_addr",  out_addr,  32'h3004);
    check("s1_level", 32'(level), 32'd1);
    drive(5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 26'h0000C03);
    tick();
    check("s2_instr", out_instr, 32'h0C00_0C03);
    check("s2_addr",  out_addr,  32'h3008);
    in_valid = 1'b0;
    tick();
    check("s3_level", 32'(level), 32'd0);
    check("s3_addr",  out_addr,  32'h300C);

    // Fill to DEPTH with out_ready low; fifth descriptor must stall
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(5'd0, 5'd0, 5'd0, 5'(k + 1), 5'd0, 26'h0);
      tick();
      check("fill_level", 32'(level), 32'(k + 1));
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    drive(5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 26'h0);
    tick();
    check("full_hold_level", 32'(level), 32'd4);
    check("full_head",       out_instr,  32'h0000_0820);
    out_ready = 1'b1;
    tick();
    check("pop_full_level", 32'(level),    32'd3);
    check("pop_full_ready", 32'(in_ready), 32'd1);
    check("pop_full_head",  out_instr,     32'h0000_1020);
    check("pop_full_addr",  out_addr,      32'h3004);
    tick();
    in_valid = 1'b0;
    check("pushpop_level", 32'(level), 32'd3);
    for (int k = 3; k <= 5; k++) begin
      check("drain_instr", out_instr, 32'(k) << 11 | 32'h20);
      check("drain_addr",  out_addr,  32'h3000 + 32'((k - 1) * 4));
      tick();
    end
    check("drain_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Illegal codes set sticky err and push nothing
    do_reset();
    drive(5'd21, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
    tick();
    check("ill21_err",   32'(err),   32'd1);
    check("ill21_level", 32'(level), 32'd0);
    drive(5'd31, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
    tick();
    in_valid = 1'b0;
    check("ill31_valid", 32'(out_valid), 32'd0);
    check("ill31_level", 32'(level),     32'd0);
    drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0);
    tick();
    in_valid = 1'b0;
    check("post_ill_instr", out_instr, 32'h0022_1820);
    check("post_ill_addr",  out_addr,  32'h3000);
    check("post_ill_err",   32'(err),  32'd1);

    // Asynchronous reset mid-stream with three words queued
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 26'(k));
      tick();
    end
    in_valid = 1'b0;
    drive(5'd25, 5'd0, 5'd0, 5'd0, 5'd0, 26'h0);
    tick();
    in_valid = 1'b0;
    check("pre_rst_level", 32'(level), 32'd3);
    check("pre_rst_err",   32'(err),   32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_level", 32'(level),     32'd0);
    check("mid_rst_err",   32'(err),       32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    reset = 1'b0;
    drive(5'd3, 5'd0, 5'd9, 5'd0, 5'd0, 26'h0000055);
    tick();
    in_valid = 1'b0;
    check("after_rst_instr", out_instr, 32'h3C09_0055);
    check("after_rst_addr",  out_addr,  32'h3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
